flash_cmd_responder: RTL and testbench

//  Device-side end of the flash command bus: receives the bytes the controller

---
 rtl/flash_cmd_responder_if.sv | 21 ++
 rtl/flash_cmd_responder.sv | 188 ++++++++++++++++++
 tb/tb_flash_cmd_responder.sv | 391 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/flash_cmd_responder_if.sv
// Byte-level command bus between a flash controller (master) and the device-side responder (slave).
interface flash_cmd_responder_if;
    logic       WrStrobe;
    logic [7:0] IOIn;
    logic       RdStrobe;
    logic [7:0] IOOut;
    logic       IOOutEn;
    logic       Busy;
    logic       Done;
    logic       CmdErr;

    modport master (
        output WrStrobe, IOIn, RdStrobe,
        input  IOOut, IOOutEn, Busy, Done, CmdErr
    );

    modport slave (
        input  WrStrobe, IOIn, RdStrobe,
        output IOOut, IOOutEn, Busy, Done, CmdErr
    );
endinterface

// File: rtl/flash_cmd_responder.sv
// Flash device model: decodes AA/55/command/address/data byte sequences and
// programs, erases or reads an internal byte array.
module flash_cmd_responder #(
    parameter int unsigned ADDR_W      = 8,
    parameter int unsigned SECT_W      = 4,
    parameter int unsigned PROG_CYCLES = 4
) (
    input  logic                  SCL,
    input  logic                  Reset,
    flash_cmd_responder_if.slave  bus
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;
    localparam int unsigned CNT_W = (PROG_CYCLES > 1) ? $clog2(PROG_CYCLES) : 1;

    localparam logic [7:0] B_UNLK1 = 8'hAA;
    localparam logic [7:0] B_UNLK2 = 8'h55;
    localparam logic [7:0] B_PROG  = 8'hB0;
    localparam logic [7:0] B_READ  = 8'hC0;
    localparam logic [7:0] B_SECT  = 8'hD0;
    localparam logic [7:0] B_CHIP  = 8'hE0;
    localparam logic [7:0] B_NOP   = 8'h00;

    typedef enum logic [2:0] {
        S_IDLE, S_UNLK1, S_UNLK2, S_ADDR, S_DATA, S_PROG, S_ERASE, S_READ
    } state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   ptr_q, ptr_d;
    logic [7:0]          cmd_q, cmd_d;
    logic                chip_q, chip_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [7:0]          ioout_q, ioout_d;
    logic                ioouten_q, ioouten_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                cmderr_q, cmderr_d;

    logic                mem_we_c;
    logic [7:0]          mem_wdata_c;
    logic                last_c;
    logic [7:0]          mem_q [DEPTH];

    // Next-state, pointer and array-write decode
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        cmd_d       = cmd_q;
        chip_d      = chip_q;
        cnt_d       = cnt_q;
        ioout_d     = ioout_q;
        ioouten_d   = 1'b0;
        done_d      = 1'b0;
        cmderr_d    = 1'b0;
        mem_we_c    = 1'b0;
        mem_wdata_c = 8'hFF;
        last_c      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.WrStrobe) begin
                    if (bus.IOIn == B_UNLK1)     state_d = S_UNLK1;
                    else if (bus.IOIn != B_NOP)  cmderr_d = 1'b1;
                end
            end
            S_UNLK1: begin
                if (bus.WrStrobe) begin
                    if (bus.IOIn == B_UNLK2) begin
                        state_d = S_UNLK2;
                    end else begin
                        state_d  = S_IDLE;
                        cmderr_d = (bus.IOIn != B_NOP);
                    end
                end
            end
            S_UNLK2: begin
                if (bus.WrStrobe) begin
                    if (bus.IOIn == B_PROG || bus.IOIn == B_READ || bus.IOIn == B_SECT) begin
                        cmd_d   = bus.IOIn;
                        state_d = S_ADDR;
                    end else if (bus.IOIn == B_CHIP) begin
                        ptr_d   = '0;
                        chip_d  = 1'b1;
                        state_d = S_ERASE;
                    end else begin
                        state_d  = S_IDLE;
                        cmderr_d = (bus.IOIn != B_NOP);
                    end
                end
            end
            S_ADDR: begin
                if (bus.WrStrobe) begin
                    ptr_d = bus.IOIn[ADDR_W-1:0];
                    if (cmd_q == B_PROG) begin
                        state_d = S_DATA;
                    end else if (cmd_q == B_READ) begin
                        state_d = S_READ;
                    end else begin
                        ptr_d   = {bus.IOIn[ADDR_W-1:SECT_W], SECT_W'(0)};
                        chip_d  = 1'b0;
                        state_d = S_ERASE;
                    end
                end
            end
            S_DATA: begin
                // Programming can only clear bits
                if (bus.WrStrobe) begin
                    mem_we_c    = 1'b1;
                    mem_wdata_c = mem_q[ptr_q] & bus.IOIn;
                    cnt_d       = CNT_W'(PROG_CYCLES - 1);
                    state_d     = S_PROG;
                end
            end
            S_PROG: begin
                cmderr_d = bus.WrStrobe;
                if (cnt_q == '0) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_ERASE: begin
                cmderr_d = bus.WrStrobe;
                mem_we_c = 1'b1;
                ptr_d    = ptr_q + ADDR_W'(1);
                last_c   = chip_q ? (&ptr_q) : (&ptr_q[SECT_W-1:0]);
                if (last_c) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end
            S_READ: begin
                // A write byte takes priority and drops a simultaneous read
                if (bus.WrStrobe) begin
                    state_d = (bus.IOIn == B_UNLK1) ? S_UNLK1 : S_IDLE;
                end else if (bus.RdStrobe) begin
                    ioout_d   = mem_q[ptr_q];
                    ioouten_d = 1'b1;
                    ptr_d     = ptr_q + ADDR_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d == S_PROG) || (state_d == S_ERASE);
    end

    always_ff @(posedge SCL) begin
        if (Reset) begin
            state_q   <= S_IDLE;
            ptr_q     <= '0;
            cmd_q     <= '0;
            chip_q    <= 1'b0;
            cnt_q     <= '0;
            ioout_q   <= 8'h00;
            ioouten_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            cmderr_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            cmd_q     <= cmd_d;
            chip_q    <= chip_d;
            cnt_q     <= cnt_d;
            ioout_q   <= ioout_d;
            ioouten_q <= ioouten_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            cmderr_q  <= cmderr_d;
        end
    end

    // Array contents survive reset; a reset cycle blocks any pending write
    always_ff @(posedge SCL) begin
        if (mem_we_c && !Reset) begin
            mem_q[ptr_q] <= mem_wdata_c;
        end
    end

    assign bus.IOOut   = ioout_q;
    assign bus.IOOutEn = ioouten_q;
    assign bus.Busy    = busy_q;
    assign bus.Done    = done_q;
    assign bus.CmdErr  = cmderr_q;

endmodule

// File: tb/tb_flash_cmd_responder.sv
// Randomised and directed bench for flash_cmd_responder against a transaction-level array model.
module tb_flash_cmd_responder;

    localparam int unsigned PROG_CYCLES = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    logic [7:0] mem_m [256];

    flash_cmd_responder_if bus ();

    flash_cmd_responder #(
        .ADDR_W     (8),
        .SECT_W     (4),
        .PROG_CYCLES(PROG_CYCLES)
    ) dut (
        .SCL  (clk),
        .Reset(rst),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, errors=%0d", errors);
        $fatal(1);
    end

    // ---------------- stimulus helpers (no checking) ----------------
    task automatic cyc(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic send(input logic [7:0] b);
        bus.WrStrobe = 1'b1;
        bus.IOIn     = b;
        @(posedge clk); #1;
        bus.WrStrobe = 1'b0;
        bus.IOIn     = 8'h00;
    endtask

    task automatic send_seq(input logic [7:0] c, input logic [7:0] a);
        send(8'hAA); send(8'h55); send(c); send(a);
    endtask

    task automatic rd(output logic en, output logic [7:0] d);
        bus.RdStrobe = 1'b1;
        @(posedge clk); #1;
        bus.RdStrobe = 1'b0;
        en = bus.IOOutEn;
        d  = bus.IOOut;
    endtask

    // Counts Busy cycles until Busy falls (bounded), returns Done in the falling cycle
    task automatic wait_done(output int n, output logic dn);
        n = 0;
        while (bus.Busy === 1'b1 && n < 1000) begin
            @(posedge clk); #1;
            n++;
        end
        dn = bus.Done;
    endtask

    // ---------------- reference model ----------------
    function automatic void m_prog(input logic [7:0] a, input logic [7:0] d);
        mem_m[a] = mem_m[a] & d;
    endfunction

    function automatic void m_sector(input logic [7:0] a);
        for (int i = 0; i < 16; i++) mem_m[(a & 8'hF0) + 8'(i)] = 8'hFF;
    endfunction

    function automatic void m_chip();
        for (int i = 0; i < 256; i++) mem_m[i] = 8'hFF;
    endfunction

    // ---------------- tests ----------------
    task automatic test_reset();
        bus.WrStrobe = 1'b0; bus.RdStrobe = 1'b0; bus.IOIn = 8'h00;
        rst = 1'b1;
        cyc(3);
        checks++;
        if ({bus.Busy, bus.Done, bus.CmdErr, bus.IOOutEn} !== 4'b0000 || bus.IOOut !== 8'h00) begin
            errors++;
            $display("FAIL reset_outputs: got busy=%b done=%b err=%b en=%b out=%h, want all 0",
                     bus.Busy, bus.Done, bus.CmdErr, bus.IOOutEn, bus.IOOut);
        end
        rst = 1'b0;
        cyc(1);
    endtask

    task automatic test_chip_erase();
        int n; logic dn, en; logic [7:0] d, ad;
        send(8'hAA); send(8'h55); send(8'hE0);
        wait_done(n, dn);
        m_chip();
        checks++;
        if (n !== 256 || dn !== 1'b1) begin
            errors++;
            $display("FAIL chip_erase_busy: busy=%0d done=%b, want 256 and 1", n, dn);
        end
        send_seq(8'hC0, 8'h00);
        for (int i = 0; i < 257; i++) begin
            ad = 8'(i);
            rd(en, d);
            checks++;
            if (en !== 1'b1 || d !== mem_m[ad]) begin
                errors++;
                $display("FAIL chip_read[%0d]: en=%b data=%h, want 1 and %h", i, en, d, mem_m[ad]);
            end
        end
    endtask

    task automatic test_program();
        int n; logic dn, en; logic [7:0] d;
        send_seq(8'hB0, 8'h12); send(8'h3C);
        wait_done(n, dn);
        m_prog(8'h12, 8'h3C);
        checks++;
        if (n !== PROG_CYCLES || dn !== 1'b1) begin
            errors++;
            $display("FAIL prog_busy: busy=%0d done=%b, want %0d and 1", n, dn, PROG_CYCLES);
        end
        cyc(1);
        checks++;
        if (bus.Done !== 1'b0) begin
            errors++;
            $display("FAIL done_width: done=%b one cycle later, want 0", bus.Done);
        end
        send_seq(8'hC0, 8'h12);
        rd(en, d);
        checks++;
        if (en !== 1'b1 || d !== 8'h3C) begin
            errors++;
            $display("FAIL prog_read: en=%b data=%h, want 1 and 3c", en, d);
        end
        cyc(1);
        checks++;
        if (bus.IOOutEn !== 1'b0) begin
            errors++;
            $display("FAIL ioouten_width: en=%b, want 0", bus.IOOutEn);
        end
        send_seq(8'hB0, 8'h12); send(8'hF0);
        wait_done(n, dn);
        m_prog(8'h12, 8'hF0);
        send_seq(8'hC0, 8'h12);
        rd(en, d);
        checks++;
        if (d !== 8'h30 || d !== mem_m[8'h12]) begin
            errors++;
            $display("FAIL prog_and: data=%h, want 30", d);
        end
    endtask

    task automatic test_sector_erase();
        int n; logic dn, en; logic [7:0] d, ad;
        send_seq(8'hB0, 8'h25); send(8'h00); wait_done(n, dn); m_prog(8'h25, 8'h00);
        send_seq(8'hB0, 8'h35); send(8'h00); wait_done(n, dn); m_prog(8'h35, 8'h00);
        send_seq(8'hD0, 8'h27);
        wait_done(n, dn);
        m_sector(8'h27);
        checks++;
        if (n !== 16 || dn !== 1'b1) begin
            errors++;
            $display("FAIL sector_busy: busy=%0d done=%b, want 16 and 1", n, dn);
        end
        send_seq(8'hC0, 8'h20);
        for (int i = 0; i < 16; i++) begin
            ad = 8'h20 + 8'(i);
            rd(en, d);
            checks++;
            if (en !== 1'b1 || d !== mem_m[ad] || d !== 8'hFF) begin
                errors++;
                $display("FAIL sector_read[%h]: en=%b data=%h, want 1 and ff", ad, en, d);
            end
        end
        send_seq(8'hC0, 8'h35);
        rd(en, d);
        checks++;
        if (d !== 8'h00) begin
            errors++;
            $display("FAIL sector_outside: data=%h at 35, want 00", d);
        end
    endtask

    task automatic test_cmd_err();
        int n; logic dn, en; logic [7:0] d;
        send(8'h00);
        send(8'hAA); send(8'h00);
        checks++;
        if (bus.CmdErr !== 1'b0) begin
            errors++;
            $display("FAIL nop_silent: cmderr=%b after AA,00, want 0", bus.CmdErr);
        end
        send(8'hAA); send(8'h77);
        checks++;
        if (bus.CmdErr !== 1'b1) begin
            errors++;
            $display("FAIL bad_unlock: cmderr=%b, want 1", bus.CmdErr);
        end
        cyc(1);
        checks++;
        if (bus.CmdErr !== 1'b0) begin
            errors++;
            $display("FAIL cmderr_width: cmderr=%b, want 0", bus.CmdErr);
        end
        send_seq(8'hB0, 8'h40); send(8'h5A);
        wait_done(n, dn);
        m_prog(8'h40, 8'h5A);
        checks++;
        if (n !== PROG_CYCLES || dn !== 1'b1) begin
            errors++;
            $display("FAIL prog_after_err: busy=%0d done=%b, want %0d and 1", n, dn, PROG_CYCLES);
        end
        send_seq(8'hB0, 8'h50); send(8'hC3);
        send(8'h11);
        checks++;
        if (bus.CmdErr !== 1'b1 || bus.Busy !== 1'b1) begin
            errors++;
            $display("FAIL busy_write: cmderr=%b busy=%b, want 1 and 1", bus.CmdErr, bus.Busy);
        end
        wait_done(n, dn);
        m_prog(8'h50, 8'hC3);
        checks++;
        if (n !== PROG_CYCLES - 1 || dn !== 1'b1) begin
            errors++;
            $display("FAIL busy_write_len: remaining busy=%0d done=%b, want %0d and 1",
                     n, dn, PROG_CYCLES - 1);
        end
        send_seq(8'hC0, 8'h40);
        rd(en, d);
        checks++;
        if (d !== mem_m[8'h40]) begin
            errors++;
            $display("FAIL read_40: data=%h, want %h", d, mem_m[8'h40]);
        end
        rd(en, d);
        rd(en, d);
        rd(en, d);
        send_seq(8'hC0, 8'h50);
        rd(en, d);
        checks++;
        if (d !== mem_m[8'h50]) begin
            errors++;
            $display("FAIL read_50: data=%h, want %h", d, mem_m[8'h50]);
        end
    endtask

    task automatic test_reset_mid_erase();
        int n; logic dn, en; logic [7:0] d, ad;
        send_seq(8'hB0, 8'hC8); send(8'h5C); wait_done(n, dn); m_prog(8'hC8, 8'h5C);
        send(8'hAA); send(8'h55); send(8'hE0);
        cyc(10);
        rst = 1'b1;
        cyc(1);
        checks++;
        if (bus.Busy !== 1'b0 || bus.Done !== 1'b0) begin
            errors++;
            $display("FAIL reset_abort: busy=%b done=%b, want 0 and 0", bus.Busy, bus.Done);
        end
        rst = 1'b0;
        for (int i = 0; i < 10; i++) mem_m[i] = 8'hFF;
        send_seq(8'hC0, 8'h00);
        for (int i = 0; i < 10; i++) begin
            ad = 8'(i);
            rd(en, d);
            checks++;
            if (en !== 1'b1 || d !== mem_m[ad]) begin
                errors++;
                $display("FAIL partial_erase[%0d]: en=%b data=%h, want 1 and %h", i, en, d, mem_m[ad]);
            end
        end
        send_seq(8'hC0, 8'hC8);
        rd(en, d);
        checks++;
        if (d !== 8'h5C) begin
            errors++;
            $display("FAIL erase_untouched: data=%h at c8, want 5c", d);
        end
    endtask

    task automatic test_collision();
        logic en; logic [7:0] d, last;
        send_seq(8'hC0, 8'h30);
        rd(en, d);
        checks++;
        if (en !== 1'b1 || d !== mem_m[8'h30]) begin
            errors++;
            $display("FAIL coll_pre: en=%b data=%h, want 1 and %h", en, d, mem_m[8'h30]);
        end
        bus.WrStrobe = 1'b1; bus.IOIn = 8'hAA; bus.RdStrobe = 1'b1;
        @(posedge clk); #1;
        bus.WrStrobe = 1'b0; bus.IOIn = 8'h00; bus.RdStrobe = 1'b0;
        checks++;
        if (bus.IOOutEn !== 1'b0) begin
            errors++;
            $display("FAIL coll_drop: en=%b, want 0", bus.IOOutEn);
        end
        send(8'h55); send(8'hC0); send(8'h35);
        rd(en, d);
        checks++;
        if (en !== 1'b1 || d !== mem_m[8'h35]) begin
            errors++;
            $display("FAIL coll_continue: en=%b data=%h, want 1 and %h", en, d, mem_m[8'h35]);
        end
        last = mem_m[8'h35];
        send(8'h00);
        checks++;
        if (bus.CmdErr !== 1'b0) begin
            errors++;
            $display("FAIL read_exit: cmderr=%b, want 0", bus.CmdErr);
        end
        rd(en, d);
        checks++;
        if (en !== 1'b0 || d !== last) begin
            errors++;
            $display("FAIL rd_outside: en=%b data=%h, want 0 and %h", en, d, last);
        end
    endtask

    task automatic test_random();
        int n, cnt; logic dn, en; logic [7:0] a, v, d, ad;
        for (int it = 0; it < 60; it++) begin
            a = 8'($urandom);
            case ($urandom_range(0, 3))
                0: begin
                    v = 8'($urandom);
                    send_seq(8'hB0, a); send(v);
                    wait_done(n, dn);
                    m_prog(a, v);
                    checks++;
                    if (n !== PROG_CYCLES || dn !== 1'b1) begin
                        errors++;
                        $display("FAIL rnd_prog[%0d]: busy=%0d done=%b", it, n, dn);
                    end
                end
                1: begin
                    send_seq(8'hD0, a);
                    wait_done(n, dn);
                    m_sector(a);
                    checks++;
                    if (n !== 16 || dn !== 1'b1) begin
                        errors++;
                        $display("FAIL rnd_sector[%0d]: busy=%0d done=%b", it, n, dn);
                    end
                end
                2: begin
                    cnt = $urandom_range(1, 8);
                    send_seq(8'hC0, a);
                    for (int i = 0; i < cnt; i++) begin
                        ad = a + 8'(i);
                        rd(en, d);
                        checks++;
                        if (en !== 1'b1 || d !== mem_m[ad]) begin
                            errors++;
                            $display("FAIL rnd_read[%h]: en=%b data=%h, want 1 and %h", ad, en, d, mem_m[ad]);
                        end
                    end
                end
                default: begin
                    v = 8'($urandom_range(1, 254));
                    if (v == 8'hAA) v = 8'h3B;
                    send(8'h00);
                    send(v);
                    checks++;
                    if (bus.CmdErr !== 1'b1) begin
                        errors++;
                        $display("FAIL rnd_bad_byte[%h]: cmderr=%b, want 1", v, bus.CmdErr);
                    end
                end
            endcase
        end
    endtask

    initial begin
        test_reset();
        test_chip_erase();
        test_program();
        test_sector_erase();
        test_cmd_err();
        test_reset_mid_erase();
        test_collision();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
